// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared state encodings, default widths and instruction field positions for the CPU front end
package cpu_defs;
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_READY = 2'd1,
    S_RUN   = 2'd2
  } state_e;
  localparam int INST_W_DEF = 12;
  localparam int NIB_W_DEF  = 4;
  localparam int OPC_LSB    = 0;
  localparam int OPC_W      = 4;
  localparam int IMM_LSB    = 4;
  localparam int IMM_W      = 8;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, DEB_CYC-cycle stability filter and one-cycle rising-edge pulse
//   clk, rst (async, active-high); btn_raw in (asynchronous); btn_edge out (one cycle per debounced rise)
module btn_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_edge
);
  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  logic          sync1_q, sync2_q, level_q, level_prev_q, edge_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      edge_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      edge_q       <= level_q & ~level_prev_q;
      if (sync2_q == level_q) cnt_q <= '0;
      else if (cnt_q == CW'(DEB_CYC - 1)) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
      end else cnt_q <= cnt_q + 1'b1;
    end
  end
  assign btn_edge = edge_q;
endmodule

// File: rtl/inst_load_ctrl.sv
// inst_load_ctrl: assembles an instruction from switch nibbles on debounced presses and hands it to the execute FSM
//   in : clk, rst (async, active-high), btn_raw, din[NIB_W], clr_inst, exec_done
//   out: btn_edge, inst_out[INST_W], opcode[4], inst_done, exec_start, load_idx, busy (all registered)
module inst_load_ctrl
  import cpu_defs::*;
#(
  parameter  int INST_W  = INST_W_DEF,
  parameter  int NIB_W   = NIB_W_DEF,
  parameter  int DEB_CYC = 4,
  localparam int NNIB    = INST_W / NIB_W,
  localparam int IDX_W   = (NNIB > 1) ? $clog2(NNIB) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_raw,
  input  logic [NIB_W-1:0]  din,
  input  logic              clr_inst,
  input  logic              exec_done,
  output logic              btn_edge,
  output logic [INST_W-1:0] inst_out,
  output logic [OPC_W-1:0]  opcode,
  output logic              inst_done,
  output logic              exec_start,
  output logic [IDX_W-1:0]  load_idx,
  output logic              busy
);
  state_e              state_q, state_d;
  logic [INST_W-1:0]   inst_q;
  logic [IDX_W-1:0]    idx_q;
  logic                done_q, start_q, busy_q;
  logic                edge_w, last, clr_ok, retire, cap, zap;
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_edge (edge_w)
  );
  assign last   = idx_q == IDX_W'(NNIB - 1);
  // a running instruction cannot be cancelled, and clear beats a simultaneous press
  assign clr_ok = clr_inst && state_q != S_RUN;
  assign retire = state_q == S_RUN && exec_done;
  assign cap    = state_q == S_LOAD && edge_w && !clr_inst;
  assign zap    = clr_ok || retire;
  always_comb begin
    state_d = zap                             ? S_LOAD  :
              (cap && last)                   ? S_READY :
              (state_q == S_READY && edge_w)  ? S_RUN   : state_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      inst_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= zap ? '0 : cap ? {din, inst_q[INST_W-1:NIB_W]} : inst_q;
      idx_q   <= (zap || (cap && last)) ? '0 : cap ? idx_q + 1'b1 : idx_q;
      done_q  <= state_d == S_READY;
      busy_q  <= state_d == S_RUN;
      start_q <= state_q == S_READY && state_d == S_RUN;
    end
  end
  assign btn_edge   = edge_w;
  assign inst_out   = inst_q;
  assign opcode     = inst_q[OPC_LSB +: OPC_W];
  assign inst_done  = done_q;
  assign exec_start = start_q;
  assign load_idx   = idx_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_inst_load_ctrl.sv
// tb_inst_load_ctrl: table-driven and scoreboarded check of nibble loading, debounce, handshake and reset
module tb_inst_load_ctrl;
  logic        clk = 1'b0, rst = 1'b1, btn_raw = 1'b0, clr_inst = 1'b0, exec_done = 1'b0;
  logic [3:0]  din = '0;
  logic        btn_edge, inst_done, exec_start, busy;
  logic [11:0] inst_out;
  logic [3:0]  opcode;
  logic [1:0]  load_idx;
  logic        snap_start, snap_busy;
  int          n_vec = 0, n_err = 0, n_edge = 0, n_start = 0;
  typedef struct {
    logic [3:0]  din;
    bit          clr;
    logic [11:0] inst;
    logic [1:0]  idx;
    bit          done;
  } vec_t;
  vec_t tbl[8];
  vec_t sb[$];
  inst_load_ctrl #(.INST_W(12), .NIB_W(4), .DEB_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .din        (din),
    .clr_inst   (clr_inst),
    .exec_done  (exec_done),
    .btn_edge   (btn_edge),
    .inst_out   (inst_out),
    .opcode     (opcode),
    .inst_done  (inst_done),
    .exec_start (exec_start),
    .load_idx   (load_idx),
    .busy       (busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (btn_edge) n_edge++;
    if (exec_start) n_start++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_edge(input int exp_lat);
    int lat = 0;
    bit seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = btn_edge;
    end
    chk("edge_latency", lat, exp_lat);
  endtask
  task automatic press(input logic [3:0] nib, input bit clr);
    int e0 = n_edge;
    din = nib;
    btn_raw = 1'b1;
    wait_edge(7);
    if (clr) clr_inst = 1'b1;
    @(negedge clk);
    clr_inst = 1'b0;
    snap_start = exec_start;
    snap_busy = busy;
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    chk("edge_count", n_edge - e0, 1);
  endtask
  task automatic apply(input int i);
    vec_t e;
    sb.push_back(tbl[i]);
    press(tbl[i].din, tbl[i].clr);
    e = sb.pop_front();
    chk("inst_out", inst_out, e.inst);
    chk("load_idx", load_idx, e.idx);
    chk("inst_done", inst_done, e.done);
    chk("opcode", opcode, e.inst[3:0]);
  endtask
  task automatic pulse_done();
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int s0, e0;
    tbl[0] = '{4'h8, 1'b0, 12'h800, 2'd1, 1'b0};
    tbl[1] = '{4'h3, 1'b0, 12'h380, 2'd2, 1'b0};
    tbl[2] = '{4'h1, 1'b0, 12'h138, 2'd0, 1'b1};
    tbl[3] = '{4'h7, 1'b0, 12'h760, 2'd2, 1'b0};
    tbl[4] = '{4'h9, 1'b1, 12'h000, 2'd0, 1'b0};
    tbl[5] = '{4'h5, 1'b0, 12'h500, 2'd1, 1'b0};
    tbl[6] = '{4'hA, 1'b0, 12'hA50, 2'd2, 1'b0};
    tbl[7] = '{4'hB, 1'b0, 12'hBA5, 2'd0, 1'b1};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inst_out", inst_out, 12'h000);
    chk("rst_load_idx", load_idx, 2'd0);
    chk("rst_outputs", {btn_edge, inst_done, exec_start, busy}, 4'b0000);
    for (int i = 0; i < 3; i++) apply(i);
    s0 = n_start;
    press(4'hF, 1'b0);
    chk("exec_start_pulse", snap_start, 1'b1);
    chk("busy_on_start", snap_busy, 1'b1);
    chk("inst_done_in_run", inst_done, 1'b0);
    chk("exec_start_count", n_start - s0, 1);
    press(4'h2, 1'b0);
    chk("run_inst_hold", inst_out, 12'h138);
    chk("run_busy_hold", busy, 1'b1);
    chk("run_start_count", n_start - s0, 1);
    pulse_done();
    chk("retire_inst", inst_out, 12'h000);
    chk("retire_state", {busy, inst_done, load_idx}, 4'b0000);
    e0 = n_edge;
    din = 4'h6;
    btn_raw = 1'b1;
    @(negedge clk);
    btn_raw = 1'b0;
    @(negedge clk);
    btn_raw = 1'b1;
    wait_edge(7);
    @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    chk("bounce_edge_count", n_edge - e0, 1);
    chk("bounce_inst", inst_out, 12'h600);
    chk("bounce_idx", load_idx, 2'd1);
    for (int i = 3; i < 6; i++) apply(i);
    pulse_done();
    chk("done_in_load_inst", inst_out, 12'h500);
    chk("done_in_load_idx", load_idx, 2'd1);
    for (int i = 6; i < 8; i++) apply(i);
    press(4'h0, 1'b0);
    chk("run_entered", busy, 1'b1);
    s0 = n_start;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", busy, 1'b0);
    chk("async_inst", inst_out, 12'h000);
    chk("async_flags", {inst_done, load_idx}, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_restart", n_start - s0, 0);
    chk("post_rst_busy", busy, 1'b0);
    press(4'hC, 1'b0);
    chk("post_rst_inst", inst_out, 12'h00C << 8);
    chk("post_rst_idx", load_idx, 2'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
